// File: rtl/snd_mix_pkg.sv
// snd_mix_pkg: shared state type, datapath widths and 16-bit saturation helper
// for the OPL sound mixing stages.
package snd_mix_pkg;
    typedef enum logic [2:0] {IDLE, MUL1, MUL2, SUM, FILT, OUT} mix_state_t;
    localparam int SND_W  = 16;
    localparam int GAIN_W = 8;
    localparam int PROD_W = 24;
    localparam int ACC_W  = 25;
    function automatic logic signed [SND_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        return v > ACC_W'(32767) ? 16'sh7fff : v < ACC_W'(-32768) ? 16'sh8000 : v[SND_W-1:0];
    endfunction
endpackage

// File: rtl/sat_s16.sv
// sat_s16: clamps an IN_W-bit signed value into the signed 16-bit range.
module sat_s16 #(
    parameter int IN_W = 20
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [15:0]     dout
);
    always_comb
        dout = din > IN_W'(32767) ? 16'sh7fff : din < IN_W'(-32768) ? 16'sh8000 : din[15:0];
endmodule

// File: rtl/dual_opl_mixer.sv
// dual_opl_mixer: per-chip gain, saturating sum and optional one-pole low-pass
// for two OPL outputs, sharing one multiplier across a small sequencer.
module dual_opl_mixer
    import snd_mix_pkg::*;
#(
    parameter int FILT_SHIFT = 2,
    parameter int GAIN_FRAC  = 5
) (
    input  logic                    clk,
    input  logic                    RESETn,
    input  logic signed [SND_W-1:0] snd1,
    input  logic signed [SND_W-1:0] snd2,
    input  logic                    sample,
    input  logic [GAIN_W-1:0]       gain1,
    input  logic [GAIN_W-1:0]       gain2,
    input  logic                    mute,
    input  logic                    filt_en,
    input  logic                    ovr_clr,
    output logic signed [SND_W-1:0] snd_out,
    output logic                    snd_valid,
    output logic                    overrun
);
    mix_state_t state, state_nx;
    logic sample_d, pending, smp_edge, busy, go, cap;
    logic signed [SND_W-1:0] s1, s2, x, y, sat_x, y_filt;
    logic [GAIN_W-1:0] g1, g2;
    logic signed [PROD_W-1:0] p, prod, mul_a, mul_b;
    logic signed [ACC_W-1:0] acc, mix;
    logic signed [SND_W:0] diff, y_step;

    assign smp_edge = sample & ~sample_d;
    assign busy     = state != IDLE;
    assign go       = smp_edge | pending;
    assign mul_a    = state == MUL1 ? PROD_W'(s1) : PROD_W'(s2);
    assign mul_b    = PROD_W'($signed({1'b0, state == MUL1 ? g1 : g2}));
    assign prod     = mul_a * mul_b;
    assign mix      = (acc + ACC_W'(p)) >>> GAIN_FRAC;
    // 17-bit difference keeps x - y exact; arithmetic shift floors toward -inf
    assign diff     = (SND_W+1)'(x) - (SND_W+1)'(y);
    assign y_step   = (SND_W+1)'(y) + (diff >>> FILT_SHIFT);
    assign y_filt   = sat16(ACC_W'(y_step));

    sat_s16 #(.IN_W(ACC_W)) u_sat (.din(mix), .dout(sat_x));

    always_ff @(posedge clk or negedge RESETn)
        if (!RESETn) state <= IDLE;
        else         state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (go ? MUL1 : IDLE) :
                   state == MUL1 ? MUL2 :
                   state == MUL2 ? SUM  :
                   state == SUM  ? FILT :
                   state == FILT ? OUT  : IDLE;

    always_comb
        cap = state == IDLE && go;

    // one strobe may wait while busy; a second one while waiting is lost
    always_ff @(posedge clk or negedge RESETn)
        if (!RESETn) begin
            sample_d <= 1'b0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            sample_d <= sample;
            pending  <= busy ? (pending | smp_edge) : (pending & smp_edge);
            overrun  <= (smp_edge & busy & pending) | (overrun & ~ovr_clr);
        end

    always_ff @(posedge clk or negedge RESETn)
        if (!RESETn) begin
            s1 <= '0;
            s2 <= '0;
            g1 <= '0;
            g2 <= '0;
            p <= '0;
            acc <= '0;
            x <= '0;
            y <= '0;
            snd_out <= '0;
            snd_valid <= 1'b0;
        end else begin
            if (cap) begin
                s1 <= snd1;
                s2 <= snd2;
                g1 <= gain1;
                g2 <= gain2;
            end
            if (state == MUL1) p <= prod;
            if (state == MUL2) begin
                acc <= ACC_W'(p);
                p   <= prod;
            end
            if (state == SUM)  x <= mute ? '0 : sat_x;
            if (state == FILT) y <= filt_en ? y_filt : x;
            if (state == OUT)  snd_out <= y;
            snd_valid <= state == OUT;
        end
endmodule
